inst_fetch: RTL

- Front-end fetch stage that produces the instruction word and its PC consumed by the instruction decoder (its `iInst` / `iCurPc` inputs).
- Generates sequential PCs and issues requests to instruction memory with a valid/ready handshake.
- Buffers in-order responses in a small FIFO and redirects on taken branches or jumps from execute.
- Drops responses that were already in flight when a redirect occurs, and inserts NOP bubbles when no instruction is available.

---
 rtl/inst_fetch_pkg.sv | 17 +
 rtl/inst_fetch_if.sv | 27 ++
 rtl/inst_fetch_fifo.sv | 53 +++++
 rtl/inst_fetch.sv | 124 ++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    FETCH_RUN,
    FETCH_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Memory request/response, decoder output and redirect signals of the fetch stage.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ready;
  logic            mem_valid;
  logic [XLEN-1:0] mem_data;
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_pc;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] cur_pc;
  logic            valid;

  modport master (
    output mem_req, mem_addr, inst, cur_pc, valid,
    input  mem_ready, mem_valid, mem_data, stall, branch_taken, branch_pc
  );

  modport slave (
    input  mem_req, mem_addr, inst, cur_pc, valid,
    output mem_ready, mem_valid, mem_data, stall, branch_taken, branch_pc
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO of fetch entries; 1-cycle write-to-read, flush wins over push.
// No internal backpressure: the caller guarantees no push while full and no pop while empty.
module inst_fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          full;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assert property (@(posedge clk) disable iff (rst) push |-> !full);
  assert property (@(posedge clk) disable iff (rst) pop |-> !empty);

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: credit-limited in-order memory requests, response FIFO, registered decoder output.
// Response to output is 2 cycles minimum; stall holds the output and credit throttles requests.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   redirect_drop;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     in_use;
  logic            credit;
  logic            accept;
  logic            drop_resp;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  fetch_entry_t    fifo_head;
  fetch_state_t    state;
  fetch_state_t    state_nxt;

  assign target   = bus.branch_pc & ~XLEN'(3);
  assign in_use   = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit   = (in_use < CREDITS);
  assign bus.mem_req  = !rst && credit && !bus.branch_taken;
  assign bus.mem_addr = pc;
  assign accept   = bus.mem_req && bus.mem_ready;

  // Outstanding already counts any responses still owed to an earlier redirect,
  // so this single figure covers both old and new stale responses.
  assign redirect_drop = outstanding - CW'(bus.mem_valid);

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.branch_taken)
      state_nxt = (redirect_drop != '0) ? FETCH_DRAIN : FETCH_RUN;
    else if (state == FETCH_DRAIN && bus.mem_valid && drop_cnt == CW'(1))
      state_nxt = FETCH_RUN;
  end

  always_comb begin
    drop_resp = bus.branch_taken || (state == FETCH_DRAIN);
  end

  assign push = bus.mem_valid && !drop_resp;
  assign pop  = !bus.stall && !bus.branch_taken && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(bus.mem_valid);
      if (bus.branch_taken) begin
        pc       <= target;
        resp_pc  <= target;
        drop_cnt <= redirect_drop;
      end else begin
        if (accept) pc <= pc + XLEN'(4);
        if (push)   resp_pc <= resp_pc + XLEN'(4);
        if (bus.mem_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  inst_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.branch_taken),
    .push     (push),
    .push_dat ('{inst: bus.mem_data, pc: resp_pc}),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  // cur_pc keeps the last delivered PC across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.valid  <= 1'b0;
      bus.inst   <= NOP_INST;
      bus.cur_pc <= '0;
    end else if (bus.branch_taken) begin
      bus.valid <= 1'b0;
      bus.inst  <= NOP_INST;
    end else if (!bus.stall) begin
      if (!fifo_empty) begin
        bus.valid  <= 1'b1;
        bus.inst   <= fifo_head.inst;
        bus.cur_pc <= fifo_head.pc;
      end else begin
        bus.valid <= 1'b0;
        bus.inst  <= NOP_INST;
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) bus.mem_valid |-> outstanding != '0);

endmodule
